// File: rtl/line_fetch_pkg.sv
// Shared definitions for the line fetcher: FSM state encoding, pixel geometry
// and the SDRAM words-per-line helper.
package line_fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_REQ   = 2'd1;
  localparam state_t ST_BURST = 2'd2;
  localparam state_t ST_GAP   = 2'd3;

  localparam int BYTES_PER_PIXEL = 3;

  // One SDRAM word carries one byte of every layer, so a line needs
  // BYTES_PER_PIXEL words per pixel.
  function automatic int words_per_line(input int pixels);
    return pixels * BYTES_PER_PIXEL;
  endfunction

endpackage

// File: rtl/line_fetch_pack.sv
// Per-layer byte-to-pixel packer: bytes enter at the top of a 24-bit
// register, so after three beats the first-received byte sits in bits [7:0].
module line_fetch_pack (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [23:0] pix_o
);

  logic [23:0] pix_q;
  logic [23:0] pix_d;

  // Next pixel value: clear wins over shift.
  always_comb begin
    pix_d = pix_q;
    if (clr_i) begin
      pix_d = '0;
    end else if (shift_i) begin
      pix_d = {byte_i, pix_q[23:8]};
    end
  end

  // Pixel shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/line_fetch.sv
// Line fetcher: reads one image line from SDRAM in bursts, packs the
// interleaved layer bytes into 24-bit pixels and strobes them downstream.
// Optional feature: define LINE_FETCH_ERR_EN to add the short_lines counter
// of line_start events that aborted an incomplete fetch.
module line_fetch
  import line_fetch_pkg::*;
#(
  parameter int LAYERS      = 2,
  parameter int LINE_PIXELS = 720,
  parameter int LINES       = 720,
  parameter int BASE_WORD   = 0,
  parameter int ADDR_W      = 25,
  parameter int END_LEAD    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  line_start,
  input  logic [9:0]            line_y,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  end_burst,
  input  logic                  data_available,
  input  logic [8*LAYERS-1:0]   rd_data,
  output logic                  pix_wr,
  output logic [24*LAYERS-1:0]  pix_data,
  output logic                  fifo_clear,
  output logic                  busy
`ifdef LINE_FETCH_ERR_EN
  ,
  output logic [15:0]           short_lines
`endif
);

  localparam int WORDS = words_per_line(LINE_PIXELS);
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LEAD_C  = (WORDS > END_LEAD) ? CNT_W'(WORDS - END_LEAD) : '0;

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [1:0]        phase_q,   phase_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              discard_q, discard_d;
  logic              eb_done_q, eb_done_d;
  logic              pix_wr_q,  pix_wr_d;
  logic              fifo_clear_q;
  logic              dav_q;

  logic [ADDR_W-1:0] ly_w;
  logic [ADDR_W-1:0] line_addr;
  logic              beat_ok;
  logic              dav_fall;
  logic              pack_clr;
  logic              pack_shift;

  // Start address of the requested line; out-of-range lines fall back to line 0.
  always_comb begin
    ly_w      = (int'(line_y) >= LINES) ? '0 : ADDR_W'(line_y);
    line_addr = ADDR_W'(BASE_WORD) + ly_w * ADDR_W'(WORDS);
  end

  // A beat is taken only inside a live burst, outside the stale tail of an
  // aborted burst, and only until the line is complete.
  assign beat_ok   = (state_q == ST_BURST) && data_available && !discard_q && (count_q < WORDS_C);
  assign dav_fall  = dav_q && !data_available && !discard_q;
  assign end_burst = beat_ok && (count_q >= LEAD_C) && !eb_done_q;

  // Fetch FSM, beat counting and pixel phase tracking.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    phase_d    = phase_q;
    addr_d     = addr_q;
    discard_d  = discard_q;
    eb_done_d  = eb_done_q;
    pix_wr_d   = 1'b0;
    pack_clr   = 1'b0;
    pack_shift = 1'b0;
    if (discard_q && !data_available) begin
      discard_d = 1'b0;
    end
    if (line_start) begin
      state_d   = ST_REQ;
      count_d   = '0;
      phase_d   = '0;
      addr_d    = line_addr;
      pack_clr  = 1'b1;
      discard_d = data_available;
      eb_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_REQ: begin
          state_d   = ST_BURST;
          eb_done_d = 1'b0;
        end
        ST_BURST: begin
          if (beat_ok) begin
            pack_shift = 1'b1;
            count_d    = count_q + CNT_W'(1);
            if (phase_q == 2'd2) begin
              phase_d  = 2'd0;
              pix_wr_d = 1'b1;
            end else begin
              phase_d = phase_q + 2'd1;
            end
            if (end_burst) begin
              eb_done_d = 1'b1;
            end
          end
          if (dav_fall) begin
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          state_d = (count_q < WORDS_C) ? ST_REQ : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control and address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      phase_q      <= '0;
      addr_q       <= '0;
      discard_q    <= 1'b0;
      eb_done_q    <= 1'b0;
      pix_wr_q     <= 1'b0;
      fifo_clear_q <= 1'b0;
      dav_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      discard_q    <= discard_d;
      eb_done_q    <= eb_done_d;
      pix_wr_q     <= pix_wr_d;
      fifo_clear_q <= line_start;
      dav_q        <= data_available;
    end
  end

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    line_fetch_pack u_pack (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (pack_clr),
      .shift_i (pack_shift),
      .byte_i  (rd_data[8*k +: 8]),
      .pix_o   (pix_data[24*k +: 24])
    );
  end

  assign rd_req     = (state_q == ST_REQ);
  assign rd_addr    = rd_req ? (addr_q + ADDR_W'(count_q)) : '0;
  assign pix_wr     = pix_wr_q;
  assign fifo_clear = fifo_clear_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef LINE_FETCH_ERR_EN
  logic [15:0] short_q, short_d;

  // Count restarts that abandoned a line before all words arrived.
  always_comb begin
    short_d = short_q;
    if (line_start && busy && (count_q < WORDS_C)) begin
      short_d = short_q + 16'd1;
    end
  end

  // Short-line counter register; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      short_q <= '0;
    end else begin
      short_q <= short_d;
    end
  end

  assign short_lines = short_q;
`endif

endmodule

// File: tb/tb_line_fetch.sv
// Scoreboard bench for line_fetch (LAYERS=2, LINE_PIXELS=4 -> 12 words/line).
module tb_line_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic        data_available = 1'b0;
  logic [15:0] rd_data = '0;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic        end_burst;
  logic        pix_wr;
  logic [47:0] pix_data;
  logic        fifo_clear;
  logic        busy;
`ifdef LINE_FETCH_ERR_EN
  logic [15:0] short_lines;
`endif

  int checks = 0;
  int failures = 0;

  int          exp_addr_q[$];
  logic [47:0] exp_pix_q[$];
  int          exp_eb_q[$];
  int          fc_pending = 0;
  int          cur_beat = -1;
  logic [15:0] bt[12];

  int          m_addr;
  logic [47:0] m_pix;
  int          m_eb;

  always #5 clk = ~clk;

  line_fetch #(
    .LAYERS(2), .LINE_PIXELS(4), .LINES(720), .BASE_WORD(0), .ADDR_W(25), .END_LEAD(2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .line_start     (line_start),
    .line_y         (line_y),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .end_burst      (end_burst),
    .data_available (data_available),
    .rd_data        (rd_data),
    .pix_wr         (pix_wr),
    .pix_data       (pix_data),
    .fifo_clear     (fifo_clear),
    .busy           (busy)
`ifdef LINE_FETCH_ERR_EN
    ,
    .short_lines    (short_lines)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rd_req) begin
      if (exp_addr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_req_unexpected: got addr %0d expected no request", rd_addr);
      end else begin
        m_addr = exp_addr_q.pop_front();
        chk("rd_addr", 64'(rd_addr), 64'(m_addr));
      end
    end
    if (pix_wr) begin
      if (exp_pix_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL pix_wr_unexpected: got data 0x%0h expected no strobe", pix_data);
      end else begin
        m_pix = exp_pix_q.pop_front();
        chk("pix_data", 64'(pix_data), 64'(m_pix));
      end
    end
    if (end_burst) begin
      if (exp_eb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL end_burst_unexpected: got pulse at beat %0d expected none", cur_beat);
      end else begin
        m_eb = exp_eb_q.pop_front();
        chk("end_burst_beat", 64'(cur_beat), 64'(m_eb));
      end
    end
    if (fifo_clear) begin
      checks++;
      if (fc_pending == 0) begin
        failures++;
        $display("FAIL fifo_clear_unexpected: got pulse expected none");
      end else begin
        fc_pending--;
      end
    end
  end

  task automatic fill(input int tag);
    for (int i = 0; i < 12; i++) bt[i] = {8'(8'h80 + tag*16 + i), 8'(tag*16 + i)};
  endtask

  function automatic logic [47:0] pix_of(input int p);
    return {bt[3*p+2][15:8], bt[3*p+1][15:8], bt[3*p][15:8],
            bt[3*p+2][7:0],  bt[3*p+1][7:0],  bt[3*p][7:0]};
  endfunction

  task automatic push_pix(input int a, input int b);
    for (int p = a; p <= b; p++) exp_pix_q.push_back(pix_of(p));
  endtask

  task automatic start_line(input logic [9:0] y, input int addr);
    @(posedge clk); #1;
    line_start = 1'b1; line_y = y;
    fc_pending++;
    exp_addr_q.push_back(addr);
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  // Wait (bounded) for a read request, then align to the first beat slot.
  task automatic wait_req(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = rd_req;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: got no rd_req expected one within 20 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic beats(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      data_available = 1'b1; rd_data = bt[i]; cur_beat = i;
      @(posedge clk); #1;
    end
  endtask

  task automatic stop_beats();
    data_available = 1'b0; cur_beat = -1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_req"},     64'(rd_req),     64'd0);
    chk({tag, "_rd_addr"},    64'(rd_addr),    64'd0);
    chk({tag, "_end_burst"},  64'(end_burst),  64'd0);
    chk({tag, "_pix_wr"},     64'(pix_wr),     64'd0);
    chk({tag, "_pix_data"},   64'(pix_data),   64'd0);
    chk({tag, "_fifo_clear"}, 64'(fifo_clear), 64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles(1);
    chk("idle_after_release_busy", 64'(busy), 64'd0);

    // Line 1 at address 12, known byte pattern in the first pixel.
    fill(1);
    bt[0] = 16'h1122; bt[1] = 16'h3344; bt[2] = 16'h5566;
    exp_pix_q.push_back({24'h553311, 24'h664422});
    push_pix(1, 3);
    exp_eb_q.push_back(10);
    start_line(10'd1, 12);
    chk("busy_in_req", 64'(busy), 64'd1);
    wait_req("t1_req");
    beats(0, 11);
    stop_beats();
    idle_cycles(4);
    chk("t1_busy_done", 64'(busy), 64'd0);

    // Burst cut after 5 beats: resume at 12+5.
    fill(2);
    push_pix(0, 3);
    exp_eb_q.push_back(10);
    start_line(10'd1, 12);
    exp_addr_q.push_back(17);
    wait_req("t2_req_a");
    beats(0, 4);
    stop_beats();
    wait_req("t2_req_b");
    beats(5, 11);
    stop_beats();
    idle_cycles(4);
    chk("t2_busy_done", 64'(busy), 64'd0);

    // Out-of-range line falls back to base address.
    fill(3);
    push_pix(0, 3);
    exp_eb_q.push_back(10);
    start_line(10'd800, 0);
    wait_req("t3_req");
    beats(0, 11);
    stop_beats();
    idle_cycles(4);

    // Restart on the 7th beat: stale tail must be dropped.
    fill(4);
    push_pix(0, 1);
    start_line(10'd2, 24);
    wait_req("t4_req");
    beats(0, 5);
    line_start = 1'b1; line_y = 10'd3;
    rd_data = 16'hDEAD; cur_beat = 6;
    fc_pending++;
    exp_addr_q.push_back(36);
    @(posedge clk); #1;
    line_start = 1'b0; rd_data = 16'hBEEF; cur_beat = 7;
    @(posedge clk); #1;
    rd_data = 16'hCAFE; cur_beat = 8;
    @(posedge clk); #1;
    stop_beats();
    @(posedge clk); #1;
    fill(5);
    push_pix(0, 3);
    exp_eb_q.push_back(10);
    beats(0, 11);
    stop_beats();
    idle_cycles(4);
    chk("t4_busy_done", 64'(busy), 64'd0);
`ifdef LINE_FETCH_ERR_EN
    chk("short_lines_after_abort", 64'(short_lines), 64'd1);
`endif

    // Asynchronous reset in the middle of a burst while pix_wr is high.
    fill(6);
    start_line(10'd0, 0);
    wait_req("t5_req");
    beats(0, 2);
    data_available = 1'b1; rd_data = bt[3]; cur_beat = 3;
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("midburst_reset");
`ifdef LINE_FETCH_ERR_EN
    chk("short_lines_reset", 64'(short_lines), 64'd0);
`endif
    stop_beats();
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles(3);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_pix_data", 64'(pix_data), 64'd0);

    chk("leftover_addr", 64'(exp_addr_q.size()), 64'd0);
    chk("leftover_pix",  64'(exp_pix_q.size()),  64'd0);
    chk("leftover_eb",   64'(exp_eb_q.size()),   64'd0);
    chk("leftover_fifo_clear", 64'(fc_pending),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
